// File: rtl/ee357_mcpu_pkg.sv
// Shared definitions for the ee357 multicycle CPU: opcodes, PCSource codes
// and a small decode helper.
package ee357_mcpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_JMP   = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] PCS_ALU = 2'b00;
  localparam logic [1:0] PCS_TGT = 2'b01;
  localparam logic [1:0] PCS_JMP = 2'b10;

  function automatic logic [31:0] sign_ext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/ee357_mcpu_pcu_br.sv
// Branch qualification and next-PC selection. Decides whether the PC loads
// this cycle, what it loads, and flags illegal source selects or misaligned
// load values.
module ee357_mcpu_pcu_br
  import ee357_mcpu_pkg::*;
(
  input  logic [1:0]  pcs,
  input  logic [5:0]  op,
  input  logic        alu_zero,
  input  logic        pcw,
  input  logic        pcwc,
  input  logic [31:0] src_alu,
  input  logic [31:0] src_tgt,
  input  logic [31:0] src_jmp,
  output logic        pc_en,
  output logic [31:0] pc_next,
  output logic        err
);

  logic        take;
  logic        load_req;
  logic        legal;
  logic [31:0] src;

  // Branch condition from the opcode currently held in the IR.
  always_comb begin
    // NOTE: every variable written here gets a default first so no path leaves it unassigned, which would infer a latch.
    take = 1'b0;
    case (op)
      OP_BEQ:  take = alu_zero;
      OP_BNE:  take = ~alu_zero;
      default: take = 1'b0;
    endcase
  end

  assign load_req = pcw | (pcwc & take);

  // Source mux; the fourth code is illegal and suppresses the load.
  always_comb begin
    src   = src_alu;
    legal = 1'b1;
    case (pcs)
      PCS_ALU: src = src_alu;
      PCS_TGT: src = src_tgt;
      PCS_JMP: src = src_jmp;
      default: legal = 1'b0;
    endcase
  end

  assign pc_en   = load_req & legal;
  assign pc_next = {src[31:2], 2'b00};
  assign err     = load_req & (~legal | (src[1:0] != 2'b00));

endmodule

// File: rtl/ee357_mcpu_pcu.sv
// Program-counter and instruction-holding unit: PC, IR, branch target,
// ALUOut and MDR registers plus IR field decode for the control unit.
module ee357_mcpu_pcu
  import ee357_mcpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pcw,
  input  logic        pcwc,
  input  logic        iord,
  input  logic        irw,
  input  logic        tw,
  input  logic [1:0]  pcs,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  func,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [31:0] imm_sx,
  output logic [31:0] target,
  output logic [31:0] aluout,
  output logic [31:0] mdr,
  output logic        pc_err
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] aluout_q;
  logic [31:0] mdr_q;
  logic        err_q, err_d;

  logic        pc_en;
  logic [31:0] pc_next;
  logic        br_err;

  ee357_mcpu_pcu_br u_br (
    .pcs      (pcs),
    .op       (ir_q[31:26]),
    .alu_zero (alu_zero),
    .pcw      (pcw),
    .pcwc     (pcwc),
    .src_alu  (alu_result),
    .src_tgt  (tgt_q),
    .src_jmp  ({pc_q[31:28], ir_q[25:0], 2'b00}),
    .pc_en    (pc_en),
    .pc_next  (pc_next),
    .err      (br_err)
  );

  // Next-state values for the command-controlled registers.
  always_comb begin
    pc_d  = pc_en ? pc_next : pc_q;
    ir_d  = irw ? mem_rdata : ir_q;
    tgt_d = tw ? alu_result : tgt_q;
    err_d = err_q | br_err;
  end

  // Register bank; ALUOut and MDR capture every cycle.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values (old target, old op).
    if (rst) begin
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      tgt_q    <= '0;
      aluout_q <= '0;
      mdr_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      tgt_q    <= tgt_d;
      aluout_q <= alu_result;
      mdr_q    <= mem_rdata;
      err_q    <= err_d;
    end
  end

  assign mem_addr = iord ? aluout_q : pc_q;
  assign pc       = pc_q;
  assign instr    = ir_q;
  assign op       = ir_q[31:26];
  assign func     = ir_q[5:0];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign imm_sx   = sign_ext16(ir_q[15:0]);
  assign target   = tgt_q;
  assign aluout   = aluout_q;
  assign mdr      = mdr_q;
  assign pc_err   = err_q;

endmodule

// File: doc/ee357_mcpu_pcu.md
# ee357_mcpu_pcu

Program-counter and instruction-holding unit of the ee357 multicycle CPU. It sits directly upstream of `ee357_mcpu_cu`. It holds the PC, the instruction register (IR), the branch target register, ALUOut and the memory data register (MDR). It feeds `op`/`func` and the instruction fields to the control unit, and it executes that unit's `pcw`, `pcwc`, `iord`, `irw`, `tw` and `pcs` commands.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.

Ports:
- `clk`  in  1  system clock; all registers update on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `pcw`  in  1  PCWrite (unconditional PC load).
- `pcwc`  in  1  PCWriteCond (branch-qualified PC load).
- `iord`  in  1  memory address select: 0 = PC, 1 = ALUOut.
- `irw`  in  1  IRWrite.
- `tw`  in  1  TargetWrite.
- `pcs`  in  2  PCSource.
- `alu_result`  in  32  combinational ALU output.
- `alu_zero`  in  1  ALU zero flag for the current cycle.
- `mem_rdata`  in  32  memory read data.
- `mem_addr`  out  32  memory address.
- `pc`  out  32  current PC.
- `instr`  out  32  IR contents.
- `op`  out  6  `instr[31:26]`, to the control unit.
- `func`  out  6  `instr[5:0]`, to the control unit.
- `rs`, `rt`, `rd`  out  5 each  `instr[25:21]`, `instr[20:16]`, `instr[15:11]`.
- `imm_sx`  out  32  sign-extended `instr[15:0]`.
- `target`  out  32  branch target register.
- `aluout`  out  32  ALUOut register.
- `mdr`  out  32  memory data register.
- `pc_err`  out  1  sticky error flag.

## Operation
- **Registers:**
  - PC loads when `pc_en = pcw | (pcwc & take)`.
  - `take = alu_zero` for BEQ (op 000100).
  - `take = ~alu_zero` for BNE (op 000101).
  - `take = 0` for any other op.
- **PC next value, selected by `pcs`:**
  - 00: `alu_result` (PC+4 in fetch).
  - 01: `target`.
  - 10: `{pc[31:28], instr[25:0], 2'b00}`.
  - 11: illegal; the PC is not written and `pc_err` is set.
- **Alignment:** the loaded PC always has bits [1:0] forced to 00. If the selected source has nonzero bits [1:0] on a load, `pc_err` is set.
- **IR:** loads `mem_rdata` when `irw=1`; otherwise holds.
- **Target:** loads `alu_result` when `tw=1`; otherwise holds.
- **ALUOut and MDR:** load `alu_result` and `mem_rdata` respectively on every edge (free-running).
- **Memory address:** `mem_addr = iord ? aluout : pc`, combinational.
- **Decode fields:** `op`, `func`, `rs`, `rt`, `rd` and `imm_sx` are combinational slices of the IR.
- **`pc_err`:** sticky; cleared only by `rst`.
- **Reset values:**
  - `pc = RESET_PC`.
  - `instr`, `target`, `aluout`, `mdr` = 0, so `op`/`func` = 0.
  - `pc_err = 0`.
  - `mem_addr = RESET_PC` (since `iord` is driven 0 by the control unit in reset).

## Timing
- Every register write takes effect on the first rising edge after the command is asserted. Outputs change in the same timestep as that edge.
- **Fetch cycle** (`pcw=1`, `irw=1`, `pcs=00`, `iord=0`): `mem_addr` = old PC during the cycle. At the edge, the PC takes PC+4 and the IR takes the fetched word. The new `op` reaches the control unit for the decode cycle.
- **Simultaneous `pcw` and `pcwc`:** `pcw` dominates (the PC loads regardless of `take`).
- **Simultaneous `tw` and `pc_en` with `pcs=01`:** the PC takes the OLD target, and the target takes `alu_result`.
- **`irw` during a branch-completion cycle:** the IR takes `mem_rdata`, and `take` uses the OLD op (pre-edge IR).
- **Reset asserted mid-operation:** all registers go to their reset values immediately (asynchronously), independent of `clk`. The first edge after `rst` is released behaves as a normal cycle.

## Structure
- Shared package `ee357_mcpu_pkg` contains:
  - opcode constants `OP_LW`, `OP_SW`, `OP_RTYPE`, `OP_BEQ`, `OP_BNE`, `OP_JMP`, `OP_ADDI`, `OP_JAL`;
  - PCSource encodings `PCS_ALU` = 00, `PCS_TGT` = 01, `PCS_JMP` = 10.
- One sub-module: `ee357_mcpu_pcu_br`, the branch-qualify/next-PC logic. Its inputs are `pcs`, `op`, `alu_zero`, `pcw`, `pcwc` and the three sources; its outputs are `pc_en`, `pc_next` and the error strobe.
- The registers live in the top module.

## Test plan
1. **Reset:** `RESET_PC`=32'h0000_0040, `rst` pulsed with no clock edge → `pc`=0x40, `mem_addr`=0x40, `op`=0, `pc_err`=0.
2. **Fetch:** `mem_rdata`=0x8C22_0004 (LW), `alu_result`=0x44, `pcw`=`irw`=1, `pcs`=00, one edge → `pc`=0x44, `op`=100011, `imm_sx`=0x4.
3. **BEQ:** IR=0x1022_0003.
   - `tw=1`, `alu_result`=0x54, one edge → `target`=0x54.
   - Then `pcwc=1`, `pcs`=01, `alu_zero=1`, one edge → `pc`=0x54.
   - Repeat with `alu_zero=0` → `pc` unchanged.
4. **BNE:** IR op 000101, `pcwc=1`, `pcs`=01, `alu_zero=0` → `pc`=`target`; with `alu_zero=1` → `pc` holds.
5. **Jump:** `pc`=0x1000_0040, IR=0x0800_0010, `pcw=1`, `pcs`=10, one edge → `pc`=0x1000_0040.
   - Then `pcs`=11, `pcw=1`, one edge → `pc` holds, `pc_err`=1.
   - `pc_err` stays 1 until `rst`.
6. **Address mux / misalign:**
   - `iord=1`, `alu_result`=0x200 latched → next cycle `mem_addr`=0x200.
   - `pcw=1`, `pcs`=00, `alu_result`=0x46 → `pc`=0x44, `pc_err`=1.
